// File: rtl/fpu_frame_ctrl_if.sv
// Beat buses and FPU launch/result signals around fpu_frame_ctrl.
// slave is the controller's view; master is the pin-mux/FPU side facing it.
interface fpu_frame_ctrl_if #(
    parameter int DATA_W = 10,
    parameter int BEAT_W = 8,
    parameter int OP_W   = 4
);
    logic [BEAT_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] num_a;
    logic [DATA_W-1:0] num_b;
    logic              start;
    logic [DATA_W-1:0] result;
    logic [BEAT_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              err;

    modport slave (
        input  in_data, in_valid, result, out_ready,
        output in_ready, op, num_a, num_b, start, out_data, out_valid, busy, err
    );

    modport master (
        output in_data, in_valid, result, out_ready,
        input  in_ready, op, num_a, num_b, start, out_data, out_valid, busy, err
    );
endinterface

// File: rtl/fpu_frame_ctrl.sv
// Frame controller: collects opcode + two operands as beats, launches the FPU, returns the result as beats.
// Optional mid-frame idle timeout enabled by defining FRAME_TIMEOUT_EN.
module fpu_frame_ctrl #(
    parameter int DATA_W  = 10,
    parameter int BEAT_W  = 8,
    parameter int OP_W    = 4,
    parameter int RES_LAT = 0,
    parameter int TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset,
    fpu_frame_ctrl_if.slave bus
);
    localparam int BEATS = (DATA_W + BEAT_W - 1) / BEAT_W;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [3:0]       LAT_LAST  = 4'(RES_LAT - 1);

    if (OP_W > BEAT_W || RES_LAT < 0 || RES_LAT > 15 || TIMEOUT < 1) begin : g_bad_cfg
        $error("fpu_frame_ctrl: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_LAUNCH,
        S_WAIT,
        S_SEND
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [3:0]        lat_cnt, lat_cnt_nx;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic [BEAT_W-1:0] out_beat;
    logic              loading, accept, out_fire, last_beat, capture, timeout_hit;

    // Overwrite the DATA_W bits belonging to beat idx; bits of the beat above DATA_W fall away.
    function automatic logic [DATA_W-1:0] place_beat(input logic [DATA_W-1:0] cur,
                                                     input logic [BEAT_W-1:0] beat,
                                                     input logic [CNT_W-1:0]  idx);
        logic [DATA_W-1:0] nxt;
        nxt = cur;
        for (int k = 0; k < DATA_W; k++) begin
            if (CNT_W'(k / BEAT_W) == idx) nxt[k] = beat[k % BEAT_W];
        end
        return nxt;
    endfunction

    assign loading   = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign accept    = bus.in_valid && ((state == S_IDLE) || loading);
    assign out_fire  = (state == S_SEND) && bus.out_ready;
    assign last_beat = (cnt == LAST_BEAT);

`ifdef FRAME_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt;

    assign timeout_hit = loading && !accept && (idle_cnt == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (loading && !accept && !timeout_hit) begin
            idle_cnt <= idle_cnt + 1'b1;
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every clocked process uses non-blocking assignments so all registers
    // update together from pre-edge values, regardless of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            lat_cnt <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            lat_cnt <= lat_cnt_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        lat_cnt_nx = lat_cnt;
        capture    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_LOAD_A;
                    cnt_nx   = '0;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                if (timeout_hit) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (accept) begin
                    if (last_beat) begin
                        state_nx = (state == S_LOAD_A) ? S_LOAD_B : S_LAUNCH;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                if (RES_LAT == 0) begin
                    capture  = 1'b1;
                    state_nx = S_SEND;
                end else begin
                    state_nx = S_WAIT;
                end
                cnt_nx     = '0;
                lat_cnt_nx = '0;
            end
            S_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    capture    = 1'b1;
                    state_nx   = S_SEND;
                    lat_cnt_nx = '0;
                end else begin
                    lat_cnt_nx = lat_cnt + 1'b1;
                end
            end
            S_SEND: begin
                if (out_fire) begin
                    if (last_beat) begin
                        state_nx = S_IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // NOTE: the operand and result registers are cleared by reset on purpose:
    // they drive the FPU directly and must read 0 whenever reset is applied.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            if (accept && state == S_IDLE)   op_q <= bus.in_data[OP_W-1:0];
            if (accept && state == S_LOAD_A) a_q  <= place_beat(a_q, bus.in_data, cnt);
            if (accept && state == S_LOAD_B) b_q  <= place_beat(b_q, bus.in_data, cnt);
            if (capture)                     res_q <= bus.result;
        end
    end

    // Current result beat, zero-padded above DATA_W; depends only on registers so it holds while stalled.
    always_comb begin
        out_beat = '0;
        for (int k = 0; k < DATA_W; k++) begin
            if (CNT_W'(k / BEAT_W) == cnt) out_beat[k % BEAT_W] = res_q[k];
        end
    end

    assign bus.in_ready  = (state == S_IDLE) || loading;
    assign bus.op        = op_q;
    assign bus.num_a     = a_q;
    assign bus.num_b     = b_q;
    assign bus.start     = (state == S_LAUNCH);
    assign bus.out_valid = (state == S_SEND);
    assign bus.out_data  = (state == S_SEND) ? out_beat : '0;
    assign bus.busy      = (state != S_IDLE);
    assign bus.err       = timeout_hit;
endmodule

// File: tb/tb_fpu_frame_ctrl.sv
// Randomized self-checking bench for fpu_frame_ctrl: one instance with RES_LAT=0, one with RES_LAT=3.
// Honours FRAME_TIMEOUT_EN (instances built with TIMEOUT=4).
module tb_fpu_frame_ctrl;
    localparam int DATA_W  = 10;
    localparam int BEAT_W  = 8;
    localparam int OP_W    = 4;
    localparam int TIMEOUT = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [BEAT_W-1:0] in_data   [2];
    logic              in_valid  [2];
    logic              out_ready [2];
    logic [DATA_W-1:0] result    [2];

    wire [1:0]             in_ready, start, out_valid, busy, err;
    wire [1:0][OP_W-1:0]   op;
    wire [1:0][DATA_W-1:0] num_a, num_b;
    wire [1:0][BEAT_W-1:0] out_data;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fpu_frame_ctrl_if #(.DATA_W(DATA_W), .BEAT_W(BEAT_W), .OP_W(OP_W)) bus ();
        assign bus.in_data   = in_data[g];
        assign bus.in_valid  = in_valid[g];
        assign bus.out_ready = out_ready[g];
        assign bus.result    = result[g];
        assign in_ready[g]   = bus.in_ready;
        assign op[g]         = bus.op;
        assign num_a[g]      = bus.num_a;
        assign num_b[g]      = bus.num_b;
        assign start[g]      = bus.start;
        assign out_data[g]   = bus.out_data;
        assign out_valid[g]  = bus.out_valid;
        assign busy[g]       = bus.busy;
        assign err[g]        = bus.err;
        fpu_frame_ctrl #(
            .DATA_W(DATA_W), .BEAT_W(BEAT_W), .OP_W(OP_W),
            .RES_LAT(g == 0 ? 0 : 3), .TIMEOUT(TIMEOUT)
        ) dut (
            .clock(clock),
            .reset(reset),
            .bus  (bus)
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Stand-in FPU: a different result every cycle, so a capture on the wrong edge shows up.
    function automatic logic [DATA_W-1:0] fpu_val(input int c, input int d);
        return DATA_W'(c * 613 + d * 97 + 5);
    endfunction

    // Reference model state
    int                cyc = 0;
    int                start_cnt  [2] = '{0, 0};
    int                exp_starts [2] = '{0, 0};
    int                start_cyc  [2] = '{0, 0};
    int                lat_obs    [2] = '{0, 0};
    int                err_cnt    [2] = '{0, 0};
    bit                prev_ov    [2] = '{0, 0};
    logic [OP_W-1:0]   exp_op     [2];
    logic [DATA_W-1:0] exp_a      [2];
    logic [DATA_W-1:0] exp_b      [2];
    logic [DATA_W-1:0] exp_res    [2];
    bit                res_fixed     = 1'b0;
    logic [DATA_W-1:0] res_fixed_val = '0;

    // Observe launches/latency and drive the FPU result, all on the falling edge.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (start[d] === 1'b1) begin
                start_cnt[d]++;
                start_cyc[d] = cyc;
                exp_res[d]   = res_fixed ? res_fixed_val : fpu_val(cyc + 1 + lat_of(d), d);
                check("launch_op", op[d], exp_op[d]);
                check("launch_num_a", num_a[d], exp_a[d]);
                check("launch_num_b", num_b[d], exp_b[d]);
                check("launch_in_ready", in_ready[d], 1'b0);
            end
            if (out_valid[d] === 1'b1 && !prev_ov[d]) lat_obs[d] = cyc - start_cyc[d];
            prev_ov[d] = (out_valid[d] === 1'b1);
            if (err[d] === 1'b1) err_cnt[d]++;
            result[d] = res_fixed ? res_fixed_val : fpu_val(cyc + 1, d);
        end
        cyc++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_beat(input int d, input logic [BEAT_W-1:0] v);
        int t = 0;
        in_data[d]  = v;
        in_valid[d] = 1'b1;
        while (in_ready[d] !== 1'b1 && t < 64) begin
            @(negedge clock);
            t++;
        end
        if (t >= 64) check("beat_accept_bound", in_ready[d], 1'b1);
        @(negedge clock);
        in_valid[d] = 1'b0;
    endtask

    task automatic send_frame(input int d, input logic [7:0] op8, input logic [15:0] a,
                              input logic [15:0] b, input bit hold, input int mid_gap);
        logic [7:0] beats [5];
        exp_op[d] = op8[OP_W-1:0];
        exp_a[d]  = a[DATA_W-1:0];
        exp_b[d]  = b[DATA_W-1:0];
        exp_starts[d]++;
        beats = '{op8, a[7:0], a[15:8], b[7:0], b[15:8]};
        for (int i = 0; i < 5; i++) begin
            send_beat(d, beats[i]);
            if (i == 2) idle(mid_gap);
            if (i < 4) idle($urandom_range(0, 2));
        end
        if (hold) begin
            in_data[d]  = 8'hEE;
            in_valid[d] = 1'b1;
        end
    endtask

    task automatic wait_out_valid(input int d);
        int t = 0;
        while (out_valid[d] !== 1'b1 && t < 64) begin
            @(negedge clock);
            t++;
        end
        check("out_valid", out_valid[d], 1'b1);
    endtask

    task automatic recv_frame(input int d, input int stall0, input int stall1);
        logic [7:0] exp_beat;
        for (int i = 0; i < 2; i++) begin
            wait_out_valid(d);
            if (i == 0) begin
                in_valid[d] = 1'b0;
                check("held_op", op[d], exp_op[d]);
                check("held_num_a", num_a[d], exp_a[d]);
                check("held_num_b", num_b[d], exp_b[d]);
            end
            exp_beat = (i == 0) ? exp_res[d][7:0] : {6'b0, exp_res[d][9:8]};
            check("out_beat", out_data[d], exp_beat);
            repeat ((i == 0) ? stall0 : stall1) begin
                @(negedge clock);
                check("stall_valid", out_valid[d], 1'b1);
                check("stall_data", out_data[d], exp_beat);
                check("stall_in_ready", in_ready[d], 1'b0);
            end
            out_ready[d] = 1'b1;
            @(negedge clock);
            out_ready[d] = 1'b0;
        end
        check("post_in_ready", in_ready[d], 1'b1);
        check("post_busy", busy[d], 1'b0);
        check("post_out_valid", out_valid[d], 1'b0);
        check("latency", lat_obs[d], 1 + lat_of(d));
        check("start_count", start_cnt[d], exp_starts[d]);
    endtask

    task automatic check_reset_values(input string where);
        for (int d = 0; d < 2; d++) begin
            check({where, "_in_ready"}, in_ready[d], 1'b1);
            check({where, "_busy"}, busy[d], 1'b0);
            check({where, "_start"}, start[d], 1'b0);
            check({where, "_out_valid"}, out_valid[d], 1'b0);
            check({where, "_out_data"}, out_data[d], '0);
            check({where, "_op"}, op[d], '0);
            check({where, "_num_a"}, num_a[d], '0);
            check({where, "_num_b"}, num_b[d], '0);
            check({where, "_err"}, err[d], 1'b0);
        end
    endtask

    // Assert reset between clock edges and look at the outputs before the next edge.
    task automatic pulse_reset(input string where);
        #2 reset = 1'b1;
        #1 check_reset_values(where);
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int exp_err;
    int rd;
    logic [7:0]  rop;
    logic [15:0] ra, rb;

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_data[d]   = '0;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            result[d]    = '0;
        end
        reset = 1'b1;
        idle(2);
        check_reset_values("por");
        reset = 1'b0;
        idle(1);

        // Directed frame on the zero-latency instance with a long output stall
        res_fixed     = 1'b1;
        res_fixed_val = 10'h3FF;
        send_frame(0, 8'h03, 16'h02AB, 16'h0155, 1'b0, 0);
        recv_frame(0, 5, 0);
        check("dir_num_a", num_a[0], 10'h2AB);
        check("dir_num_b", num_b[0], 10'h155);

        // Directed frame on the RES_LAT=3 instance, 0xEE held on the input through LAUNCH/WAIT
        res_fixed_val = 10'h123;
        send_frame(1, 8'h03, 16'h02AB, 16'h0155, 1'b1, 0);
        recv_frame(1, 0, 2);
        res_fixed = 1'b0;

        // Reset during LOAD_B, then a clean frame
        send_beat(0, 8'h05);
        send_beat(0, 8'h11);
        send_beat(0, 8'h22);
        send_beat(0, 8'h33);
        pulse_reset("rst_load_b");
        send_frame(0, 8'h09, 16'h0123, 16'h0321, 1'b0, 0);
        recv_frame(0, 0, 1);

        // Reset during SEND, then a clean frame
        send_frame(1, 8'h0A, 16'hFC3C, 16'h03C3, 1'b0, 0);
        wait_out_valid(1);
        idle(2);
        pulse_reset("rst_send");
        send_frame(1, 8'h16, 16'h0001, 16'h0200, 1'b0, 0);
        recv_frame(1, 1, 0);

`ifdef FRAME_TIMEOUT_EN
        for (int d = 0; d < 2; d++) begin
            send_beat(d, 8'h07);
            send_beat(d, 8'h44);
            for (int k = 1; k <= 5; k++) begin
                check("timeout_err", err[d], (k == 4));
                check("timeout_busy", busy[d], (k < 5));
                @(negedge clock);
            end
            check("timeout_no_start", start_cnt[d], exp_starts[d]);
            check("timeout_partial_a", num_a[d][7:0], 8'h44);
            send_frame(d, 8'h0C, 16'h0155, 16'h02AA, 1'b0, 0);
            recv_frame(d, 1, 1);
        end
        exp_err = 1;
`else
        // Without the timeout a long pause mid-frame is simply waited out
        for (int d = 0; d < 2; d++) begin
            send_frame(d, 8'h0C, 16'h0155, 16'h02AA, 1'b0, 30);
            recv_frame(d, 0, 0);
        end
        exp_err = 0;
`endif

        // Randomized frames on either instance
        for (int n = 0; n < 16; n++) begin
            rd  = $urandom_range(0, 1);
            rop = 8'($urandom);
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            send_frame(rd, rop, ra, rb, 1'($urandom_range(0, 1)), 0);
            recv_frame(rd, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        for (int d = 0; d < 2; d++) check("err_pulses", err_cnt[d], exp_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_frame_ctrl.md
# fpu_frame_ctrl

Parametrised frame controller between the chip pins and the FPU datapath, replacing the fixed 10-bit input/output buffer pair. It collects an opcode and two operands over a narrow beat bus with valid/ready handshaking, then launches the FPU with a one-cycle start pulse. After a programmable latency it captures the FPU result and returns it over the same style of beat bus. It sits between the pin mux in the chip top and the `fpu` instance.

## Interface
Parameters:
- DATA_W, 10, operand/result width
- BEAT_W, 8, beat width on the in/out buses
- OP_W, 4, opcode width (OP_W ≤ BEAT_W)
- RES_LAT, 0, cycles from start to result capture (0..15)
- TIMEOUT, 255, idle-cycle limit mid-frame (used only with FRAME_TIMEOUT_EN)

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_data  in  BEAT_W  input beat
- in_valid  in  1  in_data valid
- in_ready  out  1  controller accepts a beat
- op  out  OP_W  opcode to FPU
- num_a  out  DATA_W  operand A to FPU
- num_b  out  DATA_W  operand B to FPU
- start  out  1  one-cycle launch pulse
- result  in  DATA_W  FPU result
- out_data  out  BEAT_W  output beat
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts beat
- busy  out  1  frame in progress (any state but IDLE)
- err  out  1  one-cycle timeout pulse (0 without FRAME_TIMEOUT_EN)

## Operation
- BEATS = ceil(DATA_W/BEAT_W). Frame = 1 opcode beat (low OP_W bits used) + BEATS beats of A + BEATS beats of B, least-significant beat first. Bits of the last beat above DATA_W ignored.
- Beat accepted on a rising edge with in_valid & in_ready.
- States: IDLE (await opcode) → LOAD_A (BEATS beats) → LOAD_B (BEATS beats) → LAUNCH → WAIT (RES_LAT cycles; skipped if RES_LAT=0) → SEND (BEATS beats) → IDLE.
- in_ready = 1 in IDLE/LOAD_A/LOAD_B, else 0. start = 1 only in LAUNCH.
- op/num_a/num_b registered, written as beats arrive, held stable from LAUNCH until the next frame overwrites them.
- Result captured into a holding register at the end of the last WAIT cycle (in LAUNCH if RES_LAT=0).
- SEND: out_valid = 1, out_data = current result beat, zero-padded above DATA_W. Beat index advances on out_valid & out_ready; out_data stable while stalled.
- Beat counter wraps to 0 on each state change; width ceil(log2(BEATS+1)).
- Reset (any time, including mid-frame or mid-SEND): state IDLE, counters 0, op/num_a/num_b/result register 0, start 0, out_valid 0, out_data 0, busy 0, err 0, in_ready 1.

## Timing
- Last B beat accepted at edge N → start high for cycle N..N+1 (LAUNCH).
- Result captured at edge N+1+RES_LAT; first out_valid in that following cycle.
- Min frame-to-first-output: 2·BEATS+1 accepted beats + 1 + RES_LAT cycles.
- After last output beat accepted at edge M, in_ready = 1 from edge M; no overlap between SEND and the next frame's input.
- in_valid during LAUNCH/WAIT/SEND ignored (in_ready=0; sender must hold).

## Configuration
- FRAME_TIMEOUT_EN defined: idle counter increments each cycle in LOAD_A/LOAD_B with no accepted beat, clears on acceptance; on reaching TIMEOUT the frame is discarded, state → IDLE, err pulses 1 cycle, operand registers keep partial contents, no start issued.
- Undefined: no counter, err tied 0, controller waits indefinitely mid-frame.

## Test plan
- DATA_W=10, BEAT_W=8, RES_LAT=0: beats 0x03, 0xAB, 0x02, 0x55, 0x01 → op=3, num_a=0x2AB, num_b=0x155, start one cycle; result=0x3FF → out beats 0xFF then 0x03.
- RES_LAT=3: same frame, result changes 0x000→0x123 two cycles after start → captured 0x123 exactly 3 cycles after start; out beats 0x23, 0x01.
- out_ready low 5 cycles in SEND → out_valid held, out_data stable 0xFF; resumes on out_ready, in_ready stays 0 until second beat accepted.
- reset asserted during LOAD_B and during SEND → all outputs at reset values immediately (async), next frame after release decodes correctly.
- FRAME_TIMEOUT_EN, TIMEOUT=4: stop after 2 beats → err pulse on 4th idle cycle, busy 0, no start; subsequent full frame works.
- in_valid held high through LAUNCH/WAIT with 0xEE on in_data → ignored; num_a/num_b unchanged until next opcode beat.
